// File: rtl/xnor_popcount_accumulator.sv
// Binarized dot-product stage: XNOR activations against weights, popcount each
// beat and accumulate NUM_CHUNKS beats into one saturated, registered result.
module xnor_popcount_accumulator #(
    parameter int unsigned CHUNK_WIDTH = 8,
    parameter int unsigned NUM_CHUNKS  = 4,
    parameter int unsigned SUM_WIDTH   = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CHUNK_WIDTH-1:0] act_bits,
    input  logic [CHUNK_WIDTH-1:0] wgt_bits,
    output logic [SUM_WIDTH-1:0]   popcount,
    output logic                   valid_out
);

    localparam int unsigned AccW   = $clog2(CHUNK_WIDTH * NUM_CHUNKS + 1);
    localparam int unsigned CntW   = $clog2(NUM_CHUNKS + 1);
    localparam int unsigned SatMax = (1 << SUM_WIDTH) - 1;

    typedef enum logic [1:0] {StIdle, StAccum, StEmit} state_e;

    state_e                 state_q, state_d;
    logic [AccW-1:0]        acc_q, acc_d;
    logic [CntW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [SUM_WIDTH-1:0]   popcount_q, popcount_d;

    logic [CHUNK_WIDTH-1:0] match;
    logic [AccW-1:0]        chunk_cnt;
    logic [AccW-1:0]        sum;
    logic [CntW-1:0]        beat_cnt_inc;
    logic                   accept;

    always_comb begin
        match     = ~(act_bits ^ wgt_bits);
        chunk_cnt = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            chunk_cnt = chunk_cnt + AccW'(match[i]);
        end
    end

    assign in_ready     = (state_q != StEmit);
    assign valid_out    = (state_q == StEmit);
    assign popcount     = popcount_q;
    assign accept       = in_valid && in_ready && !flush;
    // acc and beat_cnt are zero in IDLE, so one datapath covers IDLE and ACCUM.
    assign sum          = acc_q + chunk_cnt;
    assign beat_cnt_inc = beat_cnt_q + CntW'(1);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        beat_cnt_d = beat_cnt_q;
        popcount_d = popcount_q;
        unique case (state_q)
            StIdle, StAccum: begin
                if (flush) begin
                    state_d    = StIdle;
                    acc_d      = '0;
                    beat_cnt_d = '0;
                end else if (accept) begin
                    if (beat_cnt_inc == CntW'(NUM_CHUNKS)) begin
                        state_d    = StEmit;
                        acc_d      = '0;
                        beat_cnt_d = '0;
                        if (32'(sum) > SatMax) begin
                            popcount_d = '1;
                        end else begin
                            popcount_d = SUM_WIDTH'(sum);
                        end
                    end else begin
                        state_d    = StAccum;
                        acc_d      = sum;
                        beat_cnt_d = beat_cnt_inc;
                    end
                end
            end
            StEmit: begin
                state_d    = StIdle;
                acc_d      = '0;
                beat_cnt_d = '0;
            end
            default: begin
                state_d    = StIdle;
                acc_d      = '0;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            beat_cnt_q <= '0;
            popcount_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            beat_cnt_q <= beat_cnt_d;
            popcount_q <= popcount_d;
        end
    end

endmodule

// File: tb/tb_xnor_popcount_accumulator.sv
// Directed bench: a default instance and a SUM_WIDTH=4 instance share stimulus.
module tb_xnor_popcount_accumulator;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] act_bits = '0;
    logic [7:0] wgt_bits = '0;
    logic       in_ready, valid_out;
    logic [5:0] popcount;
    logic       in_ready_s, valid_out_s;
    logic [3:0] popcount_s;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    xnor_popcount_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .act_bits  (act_bits),
        .wgt_bits  (wgt_bits),
        .popcount  (popcount),
        .valid_out (valid_out)
    );

    xnor_popcount_accumulator #(.SUM_WIDTH(4)) dut_sat (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .act_bits  (act_bits),
        .wgt_bits  (wgt_bits),
        .popcount  (popcount_s),
        .valid_out (valid_out_s)
    );

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Present one beat for one edge; returns #1 after that edge.
    task automatic send_beat(input logic [7:0] a, input logic [7:0] w);
        in_valid = 1'b1;
        act_bits = a;
        wgt_bits = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_ready", in_ready, 1);
        check("rst_valid", valid_out, 0);
        check("rst_pop", popcount, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Four matching A5 beats back-to-back
        send_beat(8'hA5, 8'hA5);
        check("b2b_hold_pop", popcount, 0);
        check("b2b_no_early_valid", valid_out, 0);
        send_beat(8'hA5, 8'hA5);
        send_beat(8'hA5, 8'hA5);
        check("b2b_no_early_valid3", valid_out, 0);
        send_beat(8'hA5, 8'hA5);
        check("b2b_valid", valid_out, 1);
        check("b2b_pop", popcount, 32);
        check("b2b_ready_emit", in_ready, 0);
        check("b2b_sat_pop", popcount_s, 15);
        idle_cycles(1);
        check("b2b_valid_drop", valid_out, 0);
        check("b2b_ready_back", in_ready, 1);
        check("b2b_pop_hold", popcount, 32);

        // Mixed patterns: 0 + 4 + 8 + 8 = 20
        send_beat(8'hFF, 8'h00);
        send_beat(8'hFF, 8'h0F);
        check("mix_hold_pop", popcount, 32);
        send_beat(8'h3C, 8'h3C);
        check("mix_no_early_valid", valid_out, 0);
        send_beat(8'h00, 8'h00);
        check("mix_valid", valid_out, 1);
        check("mix_pop", popcount, 20);
        check("mix_sat_pop", popcount_s, 15);
        idle_cycles(1);
        check("mix_single_pulse", valid_out, 0);

        // Small sum, below both saturation limits: 0 + 0 + 0 + 4 = 4
        send_beat(8'hFF, 8'h00);
        send_beat(8'hFF, 8'h00);
        send_beat(8'hFF, 8'h00);
        send_beat(8'hFF, 8'h0F);
        check("small_pop", popcount, 4);
        check("small_sat_pop", popcount_s, 4);
        idle_cycles(1);

        // Three idle cycles between beats
        for (int b = 0; b < 4; b++) begin
            send_beat(8'h5A, 8'h5A);
            if (b < 3) begin
                for (int g = 0; g < 3; g++) begin
                    check("gap_no_early_valid", valid_out, 0);
                    idle_cycles(1);
                end
            end
        end
        check("gap_valid", valid_out, 1);
        check("gap_pop", popcount, 32);
        idle_cycles(1);

        // Flush after two beats, with a simultaneous beat
        send_beat(8'h0F, 8'h0F);
        send_beat(8'h0F, 8'h0F);
        flush = 1'b1;
        send_beat(8'h0F, 8'h0F);
        flush = 1'b0;
        check("flush_no_valid", valid_out, 0);
        send_beat(8'hFF, 8'h00);
        check("flush_no_valid2", valid_out, 0);
        send_beat(8'h33, 8'h33);
        send_beat(8'h33, 8'h33);
        send_beat(8'h33, 8'h33);
        check("flush_valid", valid_out, 1);
        check("flush_pop", popcount, 24);

        // Flush during EMIT keeps the pulse and result
        flush = 1'b1;
        #1;
        check("flush_emit_valid", valid_out, 1);
        idle_cycles(1);
        flush = 1'b0;
        check("flush_emit_pop", popcount, 24);
        check("flush_emit_ready", in_ready, 1);

        // Asynchronous reset between edges during the third beat
        send_beat(8'hAA, 8'hAA);
        send_beat(8'hAA, 8'hAA);
        in_valid = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("arst_pop", popcount, 0);
        check("arst_valid", valid_out, 0);
        check("arst_ready", in_ready, 1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        send_beat(8'hFF, 8'h0F);
        send_beat(8'hFF, 8'h0F);
        send_beat(8'hFF, 8'h0F);
        check("arst_no_early_valid", valid_out, 0);
        send_beat(8'hFF, 8'h0F);
        check("arst_valid_fresh", valid_out, 1);
        check("arst_pop_fresh", popcount, 16);

        // Reset during EMIT suppresses the pulse
        #2;
        reset = 1'b0;
        #1;
        check("arst_emit_valid", valid_out, 0);
        check("arst_emit_pop", popcount, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_cycles(1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/xnor_popcount_accumulator.md
XNOR_POPCOUNT_ACCUMULATOR -- requirements
Module: xnor_popcount_accumulator

Interface
REQ-001 The block SHALL have parameter CHUNK_WIDTH, default 8: activation/weight bits accepted per input beat.
REQ-002 The block SHALL have parameter NUM_CHUNKS, default 4: beats per neuron dot product (≥1).
REQ-003 The block SHALL have parameter SUM_WIDTH, default 6: width of popcount output.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous abort of the partial accumulation.
REQ-007 The block SHALL have port in_valid, input, 1 bit: beat present on act_bits/wgt_bits.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block can accept a beat this cycle.
REQ-009 The block SHALL have port act_bits, input, CHUNK_WIDTH bits: binarized activations, 1 = +1, 0 = −1.
REQ-010 The block SHALL have port wgt_bits, input, CHUNK_WIDTH bits: binarized weights, same encoding.
REQ-011 The block SHALL have port popcount, output, SUM_WIDTH bits: registered count of matching bits over NUM_CHUNKS beats.
REQ-012 The block SHALL have port valid_out, output, 1 bit: one-cycle pulse qualifying popcount; feeds the threshold stage valid_in.

Function
REQ-013 A beat SHALL be accepted exactly when in_valid && in_ready at a rising edge.
REQ-014 Per accepted beat, the chunk count SHALL be the number of 1s in ~(act_bits ^ wgt_bits), range 0..CHUNK_WIDTH.
REQ-015 FSM states SHALL be IDLE, ACCUM and EMIT; in_ready SHALL be 1 in IDLE/ACCUM and 0 in EMIT.
REQ-016 IDLE SHALL go to ACCUM on an accepted beat (acc = chunk count, beat_cnt = 1); if NUM_CHUNKS==1 it SHALL go directly to EMIT.
REQ-017 ACCUM SHALL add each accepted beat's chunk count to acc and increment beat_cnt; no accepted beat SHALL hold all state.
REQ-018 The beat that makes beat_cnt reach NUM_CHUNKS SHALL move the FSM to EMIT and load popcount with acc + chunk count in the same edge.
REQ-019 EMIT SHALL last exactly one cycle with valid_out=1, then return to IDLE with acc=0, beat_cnt=0, valid_out=0.
REQ-020 Latency SHALL be 1 cycle: last beat accepted at edge T, so popcount/valid_out are visible after T and valid_out drops after T+1.
REQ-021 Throughput SHALL be one dot product per NUM_CHUNKS+1 cycles; in_valid during EMIT is not accepted, and upstream holds data.
REQ-022 Internal acc SHALL be clog2(CHUNK_WIDTH*NUM_CHUNKS+1) bits wide; popcount SHALL saturate at 2^SUM_WIDTH−1 if the true sum exceeds it.
REQ-023 popcount SHALL hold its last value outside EMIT; it only changes on the edge entering EMIT.
REQ-024 flush=1 in IDLE/ACCUM SHALL clear acc and beat_cnt, return to IDLE and discard any simultaneous beat.
REQ-025 flush=1 in EMIT SHALL NOT cancel the pending valid_out pulse.
REQ-026 in_valid with X data while in_ready=0 SHALL have no effect on state.

Reset
REQ-027 reset low SHALL immediately, without a clock edge, force state=IDLE, acc=0, beat_cnt=0, popcount=0 and valid_out=0; in_ready SHALL then read 1.
REQ-028 reset asserted mid-ACCUM or in EMIT SHALL discard the partial sum and suppress valid_out.
REQ-029 Release of reset SHALL be synchronised externally; the first beat SHALL be acceptable on the first edge after release.

Verification
REQ-030 Defaults, 4 beats with act_bits==wgt_bits==8'hA5 back-to-back -> valid_out pulse 1 cycle after 4th acceptance, popcount=32, in_ready=0 that cycle.
REQ-031 Beats act/wgt = FF/00, FF/0F, 3C/3C, 00/00 -> popcount = 0+4+8+8 = 20, exactly one valid_out pulse.
REQ-032 in_valid gaps of 3 idle cycles between beats -> same result as gap-free run, no early valid_out.
REQ-033 2 beats accepted, then flush=1 together with in_valid -> no valid_out; next 4 beats of all-match -> popcount=32 with no residue.
REQ-034 SUM_WIDTH=4, 4 all-match beats -> popcount=15 (saturated).
REQ-035 reset driven low between clock edges during 3rd beat -> outputs 0 immediately, in_ready=1; subsequent 4 beats -> correct fresh sum.
